// File: rtl/tlc_pkg.sv
// Shared types and default constants for the traffic-light controller front end.
package tlc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RISE_CHK = 2'd1,
        ST_HIGH     = 2'd2,
        ST_FALL_CHK = 2'd3
    } deb_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_CNT_W           = 4;
    localparam int DEF_STUCK_CYCLES    = 64;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus debounce FSM for the farm-road loop detector.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_IDLE     | no vehicle, waiting for a high synchronised sample
//   ST_RISE_CHK | counting consecutive high samples before accepting arrival
//   ST_HIGH     | vehicle present, arrival already counted
//   ST_FALL_CHK | counting consecutive low samples before declaring departure
module sensor_debounce
    import tlc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       sensor_raw,
    output logic       arrival_pulse,
    output logic       arrival,
    output logic       to_idle,
    output deb_state_e state
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DONE  = DW'(1);

    logic          s1_q;
    logic          s2_q;
    deb_state_e    state_q;
    logic [DW-1:0] dcnt_q;
    logic          arrival_pulse_q;

    // The synchroniser runs regardless of ena so a re-enable sees fresh samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sensor_raw;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            dcnt_q          <= '0;
            arrival_pulse_q <= 1'b0;
        end else begin
            arrival_pulse_q <= 1'b0;
            if (ena) begin
                case (state_q)
                    ST_IDLE: begin
                        if (s2_q) begin
                            state_q <= ST_RISE_CHK;
                            dcnt_q  <= DONE;
                        end
                    end
                    ST_RISE_CHK: begin
                        if (!s2_q) begin
                            state_q <= ST_IDLE;
                            dcnt_q  <= '0;
                        end else if (dcnt_q == DLAST) begin
                            state_q         <= ST_HIGH;
                            dcnt_q          <= '0;
                            arrival_pulse_q <= 1'b1;
                        end else begin
                            dcnt_q <= dcnt_q + DONE;
                        end
                    end
                    ST_HIGH: begin
                        if (!s2_q) begin
                            state_q <= ST_FALL_CHK;
                            dcnt_q  <= DONE;
                        end
                    end
                    ST_FALL_CHK: begin
                        // A bounce back high is the same vehicle, not a new arrival.
                        if (s2_q) begin
                            state_q <= ST_HIGH;
                            dcnt_q  <= '0;
                        end else if (dcnt_q == DLAST) begin
                            state_q <= ST_IDLE;
                            dcnt_q  <= '0;
                        end else begin
                            dcnt_q <= dcnt_q + DONE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        dcnt_q  <= '0;
                    end
                endcase
            end
        end
    end

    // Same-edge strobes so the top level updates its registers with the FSM.
    always_comb begin
        arrival = 1'b0;
        to_idle = 1'b0;
        if (ena) begin
            arrival = (state_q == ST_RISE_CHK) && s2_q && (dcnt_q == DLAST);
            to_idle = ((state_q == ST_RISE_CHK) && !s2_q) ||
                      ((state_q == ST_FALL_CHK) && !s2_q && (dcnt_q == DLAST));
        end
    end

    assign arrival_pulse = arrival_pulse_q;
    assign state         = state_q;

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Turns the raw loop-detector level into a held vehicle request with arrival
// counting and a stuck-high fail-safe.
module vehicle_sensor_conditioner
    import tlc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             sensor_raw,
    input  logic             serve_ack,
    output logic             car_req,
    output logic [CNT_W-1:0] vehicle_count,
    output logic             arrival_pulse,
    output logic             stuck_fault
);

    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [SW-1:0]    SMAX = SW'(STUCK_CYCLES);
    localparam logic [CNT_W-1:0] CMAX = '1;

    deb_state_e       deb_state;
    logic             arrival;
    logic             to_idle;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    scnt_q, scnt_d;
    logic             stuck_q, stuck_d;
    logic             car_req_q, car_req_d;

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .sensor_raw    (sensor_raw),
        .arrival_pulse (arrival_pulse),
        .arrival       (arrival),
        .to_idle       (to_idle),
        .state         (deb_state)
    );

    always_comb begin
        cnt_d     = cnt_q;
        scnt_d    = scnt_q;
        stuck_d   = stuck_q;
        car_req_d = car_req_q;
        if (ena) begin
            if (serve_ack && arrival) begin
                cnt_d = CNT_W'(1);
            end else if (serve_ack) begin
                cnt_d = '0;
            end else if (arrival && (cnt_q != CMAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            if ((deb_state == ST_HIGH) || (deb_state == ST_FALL_CHK)) begin
                if (scnt_q != SMAX) begin
                    scnt_d = scnt_q + SW'(1);
                end
            end else begin
                scnt_d = '0;
            end

            // Only a genuine departure back to IDLE proves the loop is not stuck.
            if (to_idle) begin
                stuck_d = 1'b0;
            end else if (scnt_d == SMAX) begin
                stuck_d = 1'b1;
            end

            car_req_d = (cnt_d != '0) || stuck_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            scnt_q    <= '0;
            stuck_q   <= 1'b0;
            car_req_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            scnt_q    <= scnt_d;
            stuck_q   <= stuck_d;
            car_req_q <= car_req_d;
        end
    end

    assign vehicle_count = cnt_q;
    assign stuck_fault   = stuck_q;
    assign car_req       = car_req_q;

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Directed bench for vehicle_sensor_conditioner with an arrival scoreboard.
module tb_vehicle_sensor_conditioner;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       sensor_raw;
    logic       serve_ack;
    logic       car_req;
    logic [3:0] vehicle_count;
    logic       arrival_pulse;
    logic       stuck_fault;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    vehicle_sensor_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (4),
        .STUCK_CYCLES    (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .sensor_raw    (sensor_raw),
        .serve_ack     (serve_ack),
        .car_req       (car_req),
        .vehicle_count (vehicle_count),
        .arrival_pulse (arrival_pulse),
        .stuck_fault   (stuck_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve();
        serve_ack = 1'b1;
        tick();
        serve_ack = 1'b0;
    endtask

    task automatic vehicle(input int exp_count);
        exp_q.push_back(exp_count);
        sensor_raw = 1'b1;
        repeat (8) tick();
        sensor_raw = 1'b0;
        repeat (8) tick();
    endtask

    // Scoreboard: every accepted arrival must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && arrival_pulse === 1'b1) begin
            chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("arrival_count", 32'(vehicle_count), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        sensor_raw = 1'b0;
        serve_ack  = 1'b0;
        repeat (2) tick();
        chk("rst_car_req", 32'(car_req), 32'd0);
        chk("rst_count", 32'(vehicle_count), 32'd0);
        chk("rst_pulse", 32'(arrival_pulse), 32'd0);
        chk("rst_stuck", 32'(stuck_fault), 32'd0);
        chk("rst_state", 32'(dut.deb_state), 32'd0);
        rst_n = 1'b1;

        // rise latency: pulse only after edge 5
        sensor_raw = 1'b1;
        exp_q.push_back(1);
        for (int k = 0; k <= 6; k++) begin
            tick();
            chk($sformatf("rise_pulse_e%0d", k), 32'(arrival_pulse), 32'(k == 5));
            if (k == 4) begin
                chk("rise_count_e4", 32'(vehicle_count), 32'd0);
                chk("rise_req_e4", 32'(car_req), 32'd0);
            end
            if (k == 5) begin
                chk("rise_count_e5", 32'(vehicle_count), 32'd1);
                chk("rise_req_e5", 32'(car_req), 32'd1);
            end
        end
        sensor_raw = 1'b0;
        repeat (8) tick();
        chk("fall_state", 32'(dut.deb_state), 32'd0);

        // short glitch is rejected
        sensor_raw = 1'b1;
        repeat (2) tick();
        sensor_raw = 1'b0;
        repeat (8) tick();
        chk("glitch_count", 32'(vehicle_count), 32'd1);
        chk("glitch_state", 32'(dut.deb_state), 32'd0);

        serve();
        chk("serve1_count", 32'(vehicle_count), 32'd0);
        chk("serve1_req", 32'(car_req), 32'd0);

        for (int i = 1; i <= 3; i++) vehicle(i);
        chk("three_count", 32'(vehicle_count), 32'd3);
        chk("three_req", 32'(car_req), 32'd1);
        serve();
        chk("serve3_count", 32'(vehicle_count), 32'd0);
        chk("serve3_req", 32'(car_req), 32'd0);

        // serve_ack coinciding with an arrival
        vehicle(1);
        sensor_raw = 1'b1;
        exp_q.push_back(1);
        repeat (5) tick();
        serve_ack = 1'b1;
        tick();
        serve_ack = 1'b0;
        chk("coinc_pulse", 32'(arrival_pulse), 32'd1);
        chk("coinc_count", 32'(vehicle_count), 32'd1);
        chk("coinc_req", 32'(car_req), 32'd1);
        repeat (3) tick();
        sensor_raw = 1'b0;
        repeat (8) tick();
        serve();

        // saturation at 15
        for (int i = 1; i <= 15; i++) vehicle(i);
        chk("sat_count15", 32'(vehicle_count), 32'd15);
        vehicle(15);
        chk("sat_count_hold", 32'(vehicle_count), 32'd15);
        chk("sat_req", 32'(car_req), 32'd1);
        serve();
        chk("sat_serve", 32'(vehicle_count), 32'd0);

        // stuck-high detector
        sensor_raw = 1'b1;
        exp_q.push_back(1);
        repeat (40) tick();
        chk("stuck_early", 32'(stuck_fault), 32'd0);
        repeat (40) tick();
        chk("stuck_set", 32'(stuck_fault), 32'd1);
        serve();
        chk("stuck_serve_count", 32'(vehicle_count), 32'd0);
        chk("stuck_serve_req", 32'(car_req), 32'd1);
        chk("stuck_serve_flt", 32'(stuck_fault), 32'd1);
        sensor_raw = 1'b0;
        repeat (5) tick();
        chk("stuck_hold5", 32'(stuck_fault), 32'd1);
        tick();
        chk("stuck_clear", 32'(stuck_fault), 32'd0);
        chk("stuck_clear_req", 32'(car_req), 32'd0);
        chk("stuck_clear_state", 32'(dut.deb_state), 32'd0);

        // enable freeze during RISE_CHK
        sensor_raw = 1'b1;
        exp_q.push_back(1);
        repeat (3) tick();
        chk("ena_rise_state", 32'(dut.deb_state), 32'd1);
        ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("ena_frozen_pulse", 32'(arrival_pulse), 32'd0);
        end
        chk("ena_frozen_state", 32'(dut.deb_state), 32'd1);
        chk("ena_frozen_count", 32'(vehicle_count), 32'd0);
        ena = 1'b1;
        repeat (2) tick();
        chk("ena_resume_early", 32'(arrival_pulse), 32'd0);
        tick();
        chk("ena_resume_pulse", 32'(arrival_pulse), 32'd1);
        chk("ena_resume_count", 32'(vehicle_count), 32'd1);
        ena = 1'b0;
        serve();
        chk("ena_ack_ignored", 32'(vehicle_count), 32'd1);
        ena = 1'b1;
        sensor_raw = 1'b0;
        repeat (8) tick();

        // reset in the middle of qualification
        sensor_raw = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_count", 32'(vehicle_count), 32'd0);
        chk("midrst_state", 32'(dut.deb_state), 32'd0);
        chk("midrst_req", 32'(car_req), 32'd0);
        rst_n = 1'b1;
        exp_q.push_back(1);
        for (int k = 0; k <= 6; k++) begin
            tick();
            chk($sformatf("midrst_pulse_e%0d", k), 32'(arrival_pulse), 32'(k == 5));
        end
        sensor_raw = 1'b0;
        repeat (8) tick();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vehicle_sensor_conditioner.md
# vehicle_sensor_conditioner

Upstream stage of the traffic-light controller. It turns the raw farm-road loop-detector signal into the clean, held vehicle-request level the controller samples as its sensor input `C`. The block synchronises and debounces the raw input and counts vehicle arrivals. It holds the request until the controller acknowledges service, and it flags a stuck-high detector fail-safe.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive equal synchronised samples needed to accept an edge. Must be ≥2.
- `CNT_W`, 4: width of the waiting-vehicle counter.
- `STUCK_CYCLES`, 64: enabled cycles the debounced level may stay high before a stuck fault is declared.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ena` input 1: enable. Low freezes the FSM, counters and outputs; the synchroniser keeps running.
- `sensor_raw` input 1: asynchronous loop-detector level (high = vehicle present).
- `serve_ack` input 1: single-cycle pulse from the controller when farm green begins.
- `car_req` output 1: registered request to the controller's `C`.
- `vehicle_count` output CNT_W: number of arrivals waiting for service.
- `arrival_pulse` output 1: one-cycle pulse per accepted vehicle.
- `stuck_fault` output 1: detector-stuck-high indication.

## Operation
- Synchroniser: a 2-FF chain `sensor_raw` → `s1` → `s2`. All logic uses `s2`.
- Debounce FSM states: IDLE, RISE_CHK, HIGH, FALL_CHK. A debounce counter `dcnt` is used in the CHK states.
  - IDLE: on `s2`=1 go to RISE_CHK with `dcnt`=1.
  - RISE_CHK: on `s2`=0 return to IDLE. Otherwise, if `dcnt`==D−1, go to HIGH and assert `arrival_pulse`. Otherwise increment `dcnt`.
  - HIGH: on `s2`=0 go to FALL_CHK with `dcnt`=1.
  - FALL_CHK: on `s2`=1 return to HIGH; this is not a new arrival. If `dcnt`==D−1 with `s2`=0, go to IDLE. Otherwise increment `dcnt`.
- Vehicle counter, updated on enabled cycles:
  - `serve_ack` and arrival together: count becomes 1.
  - `serve_ack` alone: count becomes 0.
  - arrival alone: increment, saturating at 2^CNT_W−1.
- `car_req` is registered as (next count ≠ 0) OR (next `stuck_fault`). It changes on the same edge as `vehicle_count`.
- Stuck detection:
  - `scnt` increments each enabled cycle in HIGH or FALL_CHK and clears in IDLE or RISE_CHK.
  - When `scnt` reaches STUCK_CYCLES, `stuck_fault` sets.
  - `stuck_fault` clears only when the FSM enters IDLE or on reset.
  - While the fault is set, `car_req` is forced to 1, so the farm road keeps getting cycled.
- `ena`=0:
  - No state or counter change.
  - `arrival_pulse` forced to 0; `serve_ack` ignored.
  - `car_req`, `vehicle_count` and `stuck_fault` hold their values.

## Timing
- Reset (asynchronous): `s1`, `s2`, state=IDLE, `dcnt`, `scnt`, `vehicle_count`, `car_req`, `arrival_pulse` and `stuck_fault` all go to 0.
- Rise latency: take edge 0 as the first edge sampling `sensor_raw`=1, held stable with `ena`=1.
  - `arrival_pulse` is high for exactly the cycle after edge D+1; with D=4 that is edge 5.
  - `car_req` and `vehicle_count` update on that same edge D+1.
- Fall latency: a vehicle leaving returns the FSM to IDLE D+1 edges after the first low sample.
- A glitch of fewer than D−1 synchronised cycles, high in IDLE or low in HIGH, produces no arrival and no state change beyond the CHK state.
- `serve_ack` takes effect on its own edge. `car_req` drops in the next cycle unless an arrival coincides or a fault is set.
- Reset asserted mid-debounce discards the partial count; no pulse is produced after release until a full qualification completes.
- Counter saturation: with count at 15 (CNT_W=4), a further arrival leaves 15 and still pulses `arrival_pulse`.

## Structure
- Shared package `tlc_pkg`: debounce state enum (2-bit), default parameter constants.
- One natural sub-module, `sensor_debounce`: synchroniser plus debounce FSM, outputs `arrival_pulse` and state. The top level holds the vehicle counter, `car_req` and stuck logic.
- `dcnt` width is $clog2(DEBOUNCE_CYCLES); `scnt` width is $clog2(STUCK_CYCLES+1), saturating.

## Test plan
- Reset, then `sensor_raw`=1 held with D=4 → `arrival_pulse` high only after edge 5, `vehicle_count`=1, `car_req`=1.
- Raw high pulse of 2 cycles in IDLE → no `arrival_pulse`, count stays 0, FSM back in IDLE.
- Three full arrivals, then `serve_ack` → count 3 then 0, `car_req` falls the cycle after the ack.
- `serve_ack` on the same edge as an arrival → count=1, `car_req` stays 1.
- Sensor held high for 70 cycles (STUCK_CYCLES=64) → `stuck_fault`=1, and `car_req`=1 even after `serve_ack`. Sensor low for 6 cycles → fault clears.
- `ena`=0 during RISE_CHK for 10 cycles → no progress and no pulse; after `ena`=1, qualification resumes from the held `dcnt`.
